// File: rtl/ru_multiport_if.sv
// Register-unit access bundle: read addresses/data, write ports and busy-scoreboard control.
interface ru_multiport_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRP  = 2,
  parameter int NWP  = 1
);
  localparam int AW = $clog2(NREG);

  logic [NRP*AW-1:0]   rs;
  logic [NRP*XLEN-1:0] RUrs;
  logic [NRP-1:0]      rs_busy;
  logic [NWP*AW-1:0]   rd;
  logic [NWP*XLEN-1:0] DataWr;
  logic [NWP-1:0]      RUWr;
  logic                busy_set;
  logic [AW-1:0]       busy_rd;

  modport master (output rs, rd, DataWr, RUWr, busy_set, busy_rd,
                  input  RUrs, rs_busy);
  modport slave  (input  rs, rd, DataWr, RUWr, busy_set, busy_rd,
                  output RUrs, rs_busy);
endinterface

// File: rtl/ru_multiport.sv
// Parametrised multi-port register unit with optional write-to-read bypass and a
// per-register busy scoreboard for multi-cycle producers.
module ru_rdport #(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter int NWP    = 1,
  parameter bit BYPASS = 1'b1,
  parameter int AW     = $clog2(NREG)
) (
  input  logic [AW-1:0]                i_rs,
  input  logic [NREG-1:0][XLEN-1:0]    i_regs,
  input  logic [NREG-1:0]              i_busy,
  input  logic [NWP-1:0]               i_we,
  input  logic [NWP-1:0][AW-1:0]       i_rd,
  input  logic [NWP-1:0][XLEN-1:0]     i_wd,
  input  logic                         i_byp_en,
  output logic [XLEN-1:0]              o_data,
  output logic                         o_busy
);
  // Ascending port scan lets the highest-index writer win, matching the stored path.
  always_comb begin
    o_data = i_regs[i_rs];
    o_busy = i_busy[i_rs];
    if (BYPASS && i_byp_en && i_rs != '0) begin
      for (int w = 0; w < NWP; w++) begin
        if (i_we[w] && i_rd[w] == i_rs) begin
          o_data = i_wd[w];
          o_busy = 1'b0;
        end
      end
    end
  end
endmodule

module ru_multiport #(
  parameter int              XLEN    = 32,
  parameter int              NREG    = 32,
  parameter int              NRP     = 2,
  parameter int              NWP     = 1,
  parameter bit              BYPASS  = 1'b1,
  parameter logic [XLEN-1:0] SP_INIT = '0
) (
  input logic           CLK,
  input logic           RST_N,
  ru_multiport_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [NRP-1:0][AW-1:0]    w_rs;
  logic [NWP-1:0][AW-1:0]    w_rd;
  logic [NWP-1:0][XLEN-1:0]  w_wd;
  logic [NREG-1:0][XLEN-1:0] w_regs;
  logic [NREG-1:0]           w_busy;
  logic [NRP-1:0][XLEN-1:0]  w_rdata;
  logic [NRP-1:0]            w_rbusy;

  assign w_rs        = bus.rs;
  assign w_rd        = bus.rd;
  assign w_wd        = bus.DataWr;
  assign bus.RUrs    = w_rdata;
  assign bus.rs_busy = w_rbusy;

  // x0 has no flops: constant zero, never busy.
  assign w_regs[0] = '0;
  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic            w_we;
    logic [XLEN-1:0] w_d;
    logic [XLEN-1:0] r_q;
    logic            r_busy;

    always_comb begin
      w_we = 1'b0;
      w_d  = r_q;
      for (int w = 0; w < NWP; w++) begin
        if (bus.RUWr[w] && w_rd[w] == AW'(r)) begin
          w_we = 1'b1;
          w_d  = w_wd[w];
        end
      end
    end

    // A new producer claimed in the same cycle as a write supersedes that write.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        r_q    <= (r == 2) ? SP_INIT : '0;
        r_busy <= 1'b0;
      end else begin
        if (w_we) r_q <= w_d;
        if (bus.busy_set && bus.busy_rd == AW'(r)) r_busy <= 1'b1;
        else if (w_we)                             r_busy <= 1'b0;
      end
    end

    assign w_regs[r] = r_q;
    assign w_busy[r] = r_busy;
  end

  // Bypass is held off during reset so outputs show the reset image only.
  for (genvar p = 0; p < NRP; p++) begin : g_rp
    ru_rdport #(.XLEN(XLEN), .NREG(NREG), .NWP(NWP), .BYPASS(BYPASS), .AW(AW)) u_rp (
      .i_rs     (w_rs[p]),
      .i_regs   (w_regs),
      .i_busy   (w_busy),
      .i_we     (bus.RUWr),
      .i_rd     (w_rd),
      .i_wd     (w_wd),
      .i_byp_en (RST_N),
      .o_data   (w_rdata[p]),
      .o_busy   (w_rbusy[p])
    );
  end
endmodule

// File: tb/tb_ru_multiport.sv
// Drives a bypassing and a non-bypassing register unit with identical stimulus and
// compares both against an array-based architectural model.
module tb_ru_multiport;
  localparam int          XLEN = 32, NREG = 32, NRP = 2, NWP = 2, AW = 5;
  localparam logic [31:0] SP   = 32'h0000_3FFC;

  logic CLK   = 1'b0;
  logic RST_N = 1'b1;
  always #5 CLK = ~CLK;

  ru_multiport_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) ifb ();
  ru_multiport_if #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) ifn ();

  ru_multiport #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1'b1), .SP_INIT(SP))
    u_byp (.CLK(CLK), .RST_N(RST_N), .bus(ifb));
  ru_multiport #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP), .BYPASS(1'b0), .SP_INIT(SP))
    u_nob (.CLK(CLK), .RST_N(RST_N), .bus(ifn));

  logic [NRP-1:0][AW-1:0]   s_rs;
  logic [NWP-1:0][AW-1:0]   s_rd;
  logic [NWP-1:0][XLEN-1:0] s_wd;
  logic [NWP-1:0]           s_we;
  logic                     s_bset;
  logic [AW-1:0]            s_brd;

  assign ifb.rs = s_rs;  assign ifb.rd = s_rd;  assign ifb.DataWr = s_wd;
  assign ifb.RUWr = s_we; assign ifb.busy_set = s_bset; assign ifb.busy_rd = s_brd;
  assign ifn.rs = s_rs;  assign ifn.rd = s_rd;  assign ifn.DataWr = s_wd;
  assign ifn.RUWr = s_we; assign ifn.busy_set = s_bset; assign ifn.busy_rd = s_brd;

  logic [31:0] m_reg  [NREG];
  bit          m_busy [NREG];
  int          n_vec, n_err;

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_reg[r]  = (r == 2) ? SP : 32'd0;
      m_busy[r] = 1'b0;
    end
  endtask

  task automatic model_commit();
    for (int w = 0; w < NWP; w++)
      if (s_we[w] && s_rd[w] != 0) begin
        m_reg[s_rd[w]]  = s_wd[w];
        m_busy[s_rd[w]] = 1'b0;
      end
    if (s_bset && s_brd != 0) m_busy[s_brd] = 1'b1;
  endtask

  function automatic logic [31:0] exp_data(bit byp, int a);
    logic [31:0] v;
    v = (a == 0) ? 32'd0 : m_reg[a];
    if (byp && RST_N && a != 0)
      for (int w = 0; w < NWP; w++)
        if (s_we[w] && int'(s_rd[w]) == a) v = s_wd[w];
    return v;
  endfunction

  function automatic logic [31:0] exp_busy(bit byp, int a);
    logic b;
    b = (a == 0) ? 1'b0 : m_busy[a];
    if (byp && RST_N && a != 0)
      for (int w = 0; w < NWP; w++)
        if (s_we[w] && int'(s_rd[w]) == a) b = 1'b0;
    return {31'd0, b};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int p = 0; p < NRP; p++) begin
      chk($sformatf("%s byp data%0d", tag, p), ifb.RUrs[p*XLEN +: XLEN], exp_data(1'b1, s_rs[p]));
      chk($sformatf("%s byp busy%0d", tag, p), {31'd0, ifb.rs_busy[p]},  exp_busy(1'b1, s_rs[p]));
      chk($sformatf("%s nob data%0d", tag, p), ifn.RUrs[p*XLEN +: XLEN], exp_data(1'b0, s_rs[p]));
      chk($sformatf("%s nob busy%0d", tag, p), {31'd0, ifn.rs_busy[p]},  exp_busy(1'b0, s_rs[p]));
    end
  endtask

  // Called 2 time units after the falling edge: check, take the rising edge, realign.
  task automatic step(string tag);
    check_all(tag);
    @(posedge CLK);
    if (RST_N) model_commit();
    @(negedge CLK);
  endtask

  task automatic idle();
    s_we = '0; s_bset = 1'b0; s_brd = '0; s_rd = '0; s_wd = '0;
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    idle(); s_rs = '0;

    // Asynchronous reset mid-cycle, no clock edge involved.
    #3 RST_N = 1'b0; model_reset();
    #1 s_rs[0] = 5'd2; s_rs[1] = 5'd7;
    #0.5 chk("reset sp", ifb.RUrs[31:0], SP);
    chk("reset r7", ifb.RUrs[63:32], 32'd0);
    check_all("reset");
    @(negedge CLK); #2 RST_N = 1'b1;
    @(negedge CLK);

    // Single writes, then x0 write ignored.
    s_we[0] = 1'b1; s_rd[0] = 5'd1; s_wd[0] = 32'd32; #2 step("wr1");
    s_rd[0] = 5'd2; s_wd[0] = 32'd22;                 #2 step("wr2");
    idle(); s_rs[0] = 5'd1; s_rs[1] = 5'd2; #2
    chk("rd r1", ifn.RUrs[31:0], 32'd32);
    chk("rd r2", ifn.RUrs[63:32], 32'd22);
    step("rd12");
    s_we[0] = 1'b1; s_rd[0] = 5'd0; s_wd[0] = 32'd12; s_rs[0] = 5'd0; #2 step("wr0");
    idle(); #2 chk("rd x0", ifb.RUrs[31:0], 32'd0); step("rdx0");

    // Bypass versus stored path.
    s_we[0] = 1'b1; s_rd[0] = 5'd5; s_wd[0] = 32'd6; s_rs[0] = 5'd5; #2
    chk("bypass same cycle", ifb.RUrs[31:0], 32'd6);
    chk("no bypass old", ifn.RUrs[31:0], 32'd0);
    step("byp");
    idle(); #2 chk("no bypass after edge", ifn.RUrs[31:0], 32'd6); step("byp2");

    // Dual-port conflict: port 1 wins.
    s_we = 2'b11; s_rd[0] = 5'd7; s_rd[1] = 5'd7; s_wd[0] = 32'd14; s_wd[1] = 32'd23; s_rs[0] = 5'd7; #2
    chk("conflict bypass", ifb.RUrs[31:0], 32'd23);
    step("conf");
    idle(); #2 chk("conflict stored", ifn.RUrs[31:0], 32'd23); step("conf2");

    // Scoreboard.
    s_bset = 1'b1; s_brd = 5'd9; s_rs[0] = 5'd9; #2 step("bset");
    idle(); #2 chk("busy set", {31'd0, ifn.rs_busy[0]}, 32'd1); step("bset2");
    s_we[0] = 1'b1; s_rd[0] = 5'd9; s_wd[0] = 32'd5; s_bset = 1'b1; s_brd = 5'd9; #2
    chk("busy byp forced", {31'd0, ifb.rs_busy[0]}, 32'd0);
    step("setwin");
    idle(); #2 chk("set wins", {31'd0, ifn.rs_busy[0]}, 32'd1); step("setwin2");
    s_we[0] = 1'b1; s_rd[0] = 5'd9; s_wd[0] = 32'd8; #2 step("clr");
    idle(); #2 chk("busy cleared", {31'd0, ifn.rs_busy[0]}, 32'd0); step("clr2");
    s_bset = 1'b1; s_brd = 5'd0; s_rs[0] = 5'd0; #2 step("bset0");
    idle(); #2 chk("x0 never busy", {31'd0, ifn.rs_busy[0]}, 32'd0); step("bset02");

    // Randomised traffic, addresses narrowed to force hits and conflicts.
    for (int i = 0; i < 300; i++) begin
      for (int p = 0; p < NRP; p++) s_rs[p] = AW'($urandom_range(0, 15));
      for (int w = 0; w < NWP; w++) begin
        s_we[w] = 1'($urandom_range(0, 1));
        s_rd[w] = AW'($urandom_range(0, 15));
        s_wd[w] = $urandom;
      end
      s_bset = 1'($urandom_range(0, 3) == 0);
      s_brd  = AW'($urandom_range(0, 15));
      #2 step("rand");
    end

    // Reset mid-operation with a write and busy-set in flight.
    idle(); s_we[0] = 1'b1; s_rd[0] = 5'd3; s_wd[0] = 32'd77; #2 step("pre3");
    s_rd[0] = 5'd3; s_wd[0] = 32'd99; s_bset = 1'b1; s_brd = 5'd4;
    #2 RST_N = 1'b0; model_reset();
    for (int a = 0; a < NREG; a++) begin
      s_rs[0] = AW'(a); s_rs[1] = AW'(NREG - 1 - a);
      #1 check_all("rst scan");
    end
    @(negedge CLK); #2 RST_N = 1'b1; idle();
    s_rs[0] = 5'd3; s_rs[1] = 5'd4;
    #1 chk("inflight discarded", ifn.RUrs[31:0], 32'd0);
    chk("busy after rst", {31'd0, ifn.rs_busy[1]}, 32'd0);
    @(negedge CLK); #2 step("post rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/ru_multiport.md
# ru_multiport

Parametrised register unit for the single-cycle RISC-V core, successor to the fixed 32×32, 2-read/1-write register file. Width, depth, read-port count and write-port count are generic. Adds asynchronous reset, a configurable stack-pointer reset value and an optional write-to-read bypass. A per-register busy scoreboard supports multi-cycle producers such as a future load unit or M-extension divider.

## Interface
- XLEN, 32, data width in bits
- NREG, 32, number of architectural registers (power of two, ≥4); AW = $clog2(NREG)
- NRP, 2, number of read ports (1..4)
- NWP, 1, number of write ports (1..2)
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored value
- SP_INIT, 32'h0000_0000, reset value of register 2 (sp)

- CLK  in  1  clock, rising edge active
- RST_N  in  1  asynchronous, active-low reset
- rs  in  NRP*AW  read addresses; port p = rs[p*AW +: AW]
- RUrs  out  NRP*XLEN  read data; port p = RUrs[p*XLEN +: XLEN]
- rs_busy  out  NRP  scoreboard busy flag per read port
- rd  in  NWP*AW  write addresses, packed as rs
- DataWr  in  NWP*XLEN  write data, packed as RUrs
- RUWr  in  NWP  write enable per write port
- busy_set  in  1  mark register busy_rd as having a pending producer
- busy_rd  in  AW  register to mark busy

## Operation
- Storage: NREG × XLEN flops plus NREG busy bits. Register 0 is not stored: it always reads 0 and is never busy.
- Reset (RST_N low, asynchronous):
  - all registers clear to 0, except register 2, which takes SP_INIT
  - all busy bits clear
  - takes effect immediately; no edge is required
  - state holds while RST_N is low
  - a write in flight when reset asserts is discarded
- Write, on CLK rising edge:
  - for each port w with RUWr[w]=1 and rd[w]≠0, the register takes DataWr[w]
  - writes to register 0 are ignored
- Write conflict: if two ports write the same register in the same cycle, the higher-index port wins.
- Read: combinational. RUrs[p] = register value at rs[p]; 0 when rs[p]=0.
- Bypass (BYPASS=1):
  - if any enabled write port targets rs[p]≠0 in the current cycle, RUrs[p] returns that port's DataWr
  - under a write conflict, the winning port's data is returned
  - with BYPASS=0, RUrs[p] returns the old value until after the edge
- Scoreboard:
  - busy_set=1 with busy_rd≠0 sets busy[busy_rd] at the edge
  - any enabled write to register r clears busy[r] at the edge
  - if busy_set targets the same register as a write in the same cycle, set wins: the register ends busy, because a new producer supersedes
  - rs_busy[p] = busy[rs[p]]
  - with BYPASS=1, rs_busy[p] is forced to 0 when an enabled write targets rs[p] in the current cycle
  - rs_busy is always 0 for register 0
- Out-of-range addresses cannot occur (NREG is a power of two).

## Timing
- Read latency: 0 cycles (combinational from rs).
- Write latency: 1 edge. Data is visible on the stored path the cycle after RUWr; with BYPASS=1 it is visible in the same cycle.
- Busy set: visible on rs_busy the cycle after busy_set.
- Busy clear: visible the cycle after the write, or the same cycle with BYPASS=1.
- Output values during and immediately after reset:
  - RUrs = 0 for every address except 2, which reads SP_INIT
  - rs_busy = 0
- No handshake. Writes are unconditional when enabled, and there is no stall or back-pressure.
- Deassertion of RST_N must be synchronised externally; the block assumes RST_N releases away from the CLK edge.

## Test plan
- Reset with SP_INIT=32'h0000_3FFC: assert RST_N=0 mid-cycle, with no clock edge -> all RUrs read 0 immediately, except rs=2 -> 32'h0000_3FFC; rs_busy=0.
- Single write: rd=1, DataWr=32, RUWr=1, then rd=2, DataWr=22 on the next edge; then rs0=1, rs1=2 -> RUrs 32 and 22. Write rd=0, DataWr=12 -> rs=0 reads 0.
- Bypass: BYPASS=1, rd=5, DataWr=6, RUWr=1, rs0=5 in the same cycle -> RUrs0=6 before the edge. Repeat with BYPASS=0 -> old value 0 before the edge, 6 after.
- Dual-port conflict: NWP=2, both ports write rd=7, with DataWr 14 (port 0) and 23 (port 1) -> register 7 = 23; the bypassed read also returns 23.
- Scoreboard: busy_set, busy_rd=9 -> rs_busy=1 on rs=9 next cycle. Write rd=9 with busy_set, busy_rd=9 in the same cycle -> still busy. Write rd=9 alone -> busy clears. busy_set on rd=0 -> never busy.
- Reset mid-operation: RUWr=1, rd=3, DataWr=99, with RST_N pulled low before the edge -> register 3 reads 0 after release; busy bits remain 0.
